iob_master_ka10: RTL and testbench
==================================

Name: iob_master_ka10

Overview:
- Processor-side initiator for the KA10 IO bus; the counterpart of the bus-responder device controllers (tty, etc.).
- Takes one IOT command at a time over a valid/ready handshake and sequences ios/iob_in and the clear/set/strobe levels for DATAO, CONO, DATAI, CONI, CONSZ, CONSO and IORESET.
- Returns read data and skip results; synchronises the device PI request lines for the PI system.

Parameters:
- SETUP_CYC, 2, cycles ios/iob_in are stable before any strobe
- CLR_CYC, 4, cycles a *_clear level is held
- GAP_CYC, 2, idle cycles between the clear and set phases
- SET_CYC, 4, cycles a *_set level is held
- RD_CYC, 4, cycles iob_fm_datai/iob_fm_status is held; sampling happens on the last cycle
- RST_CYC, 8, cycles iob_reset is held
- PWR_DLY, 16, cycles after reset release before iob_poweron rises

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master idle and able to accept a command
- cmd_op  in  3  0 DATAO, 1 CONO, 2 DATAI, 3 CONI, 4 CONSZ, 5 CONSO, 6 IORESET, 7 NOP
- cmd_dev  in  7 [3:9]  device select code
- cmd_data  in  36 [0:35]  DATAO/CONO word; for CONSZ/CONSO, mask in [18:35]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  36 [0:35]  word sampled from iob_out (0 for write ops)
- rsp_skip  out  1  skip result for CONSZ/CONSO, otherwise 0
- iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set, iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status  out  1 each  bus levels
- iobus_ios  out  7 [3:9]  device select
- iobus_iob_in  out  36 [0:35]  data to devices
- iobus_iob_out  in  36 [0:35]  wired-OR data from devices
- iobus_pi_req  in  7 [1:7]  device PI requests
- pi_req_sync  out  7 [1:7]  two-flop synchronised copy of iobus_pi_req

Behaviour:
- Reset (async, while reset low):
  - all bus levels 0, ios 0, iob_in 0, rsp_* 0, pi_req_sync 0, FSM in IDLE.
  - After release, iob_poweron rises after PWR_DLY cycles.
  - cmd_ready stays 0 until iob_poweron is 1.
- Accept: cmd_valid & cmd_ready in the same cycle latches op, dev and data.
  - cmd_ready drops the next cycle and stays low until the cycle after rsp_valid.
- FSM states: IDLE, SETUP, CLR, GAP, SET, READ, RST, DONE. A per-state down-counter loads N-1 on entry.
- Write ops (DATAO/CONO):
  - Path: IDLE→SETUP→CLR→GAP→SET→SETUP(hold, 1 cycle)→DONE.
  - ios and iob_in are driven from SETUP through the hold cycle; both are 0 in IDLE.
  - CLR drives datao_clear or cono_clear; SET drives datao_set or cono_set.
- Read ops (DATAI/CONI/CONSZ/CONSO):
  - Path: IDLE→SETUP→READ→DONE. iob_in is 0 throughout.
  - READ drives fm_datai (DATAI) or fm_status (others).
  - iob_out is registered on the last READ cycle.
  - Skip rules: CONSZ skips when (sample[18:35] & mask)==0; CONSO skips when nonzero.
  - rsp_data holds the full sample for all read ops.
- IORESET: IDLE→RST→DONE. iob_reset held RST_CYC; ios not driven.
- NOP: IDLE→DONE.
- DONE: rsp_valid=1 for exactly one cycle; rsp_data/rsp_skip valid with it and held until the next accept. Then back to IDLE.
- Latency from the accept cycle to rsp_valid:
  - DATAO/CONO: SETUP+CLR+GAP+SET+2 cycles (defaults: 14).
  - Read ops: SETUP+RD+1 cycles (defaults: 7).
  - IORESET: RST+1 cycles (defaults: 9).
- Exclusivity: at most one of the clear/set/fm/reset levels is high in any cycle, and every level has at least one low cycle between assertions, so responder edge detectors see distinct edges on back-to-back commands.
- Back-to-back: a command presented during DONE is not accepted. The earliest accept is the IDLE cycle after DONE.
- Reset mid-operation: all levels drop immediately (async), the in-flight command is discarded and no rsp_valid is produced. iob_poweron drops and the PWR_DLY sequence restarts.
- Invalid cycle counts: parameters below 1 are illegal; the implementation checks this under simulation.

Decomposition:
- Shared package iob_ka10_pkg:
  - op codes IOB_DATAO..IOB_NOP
  - FSM state enum
  - the tty device code constant 7'b001_010_0
- One natural sub-module: iob_sync7, the two-flop PI request synchroniser with async active-low clear.

Test Plan:
1. Power-on: release reset → iob_poweron high at cycle 16 and cmd_ready high; no bus level toggles before then.
2. DATAO to tty (dev 0010100, data 0o101):
   - ios=0010100 and iob_in[28:35]=0o101 for the whole op.
   - datao_clear high 4 cycles, gap 2 cycles, datao_set high 4 cycles.
   - rsp_valid 14 cycles after the accept.
3. CONI with a responder model driving iob_out=0o000000000123 while fm_status is high:
   - rsp_data=0o123, rsp_skip=0.
   - CONSO with mask 0o20 → skip=1; CONSZ with mask 0o4 → skip=1; CONSZ with mask 0o1 → skip=0.
4. Back-to-back DATAI then CONO with cmd_valid held high → second accept in the IDLE cycle after DONE; no overlap of fm_datai and cono_clear; at least one low cycle between levels.
5. Assert reset in the 3rd cycle of CLR during a CONO → cono_clear drops in the same cycle, no rsp_valid, poweron restarts its 16-cycle delay.
6. Drive iobus_pi_req=7'b0010000 asynchronously → pi_req_sync matches within 2 clocks. IORESET → iob_reset high exactly 8 cycles, then rsp_valid.

Source files
------------

// File: rtl/iob_ka10_pkg.sv
// Shared definitions for the KA10 IO bus master: IOT op codes, FSM states,
// device codes and the state down-counter load helper.
package iob_ka10_pkg;

    localparam logic [2:0] IOB_DATAO   = 3'd0;
    localparam logic [2:0] IOB_CONO    = 3'd1;
    localparam logic [2:0] IOB_DATAI   = 3'd2;
    localparam logic [2:0] IOB_CONI    = 3'd3;
    localparam logic [2:0] IOB_CONSZ   = 3'd4;
    localparam logic [2:0] IOB_CONSO   = 3'd5;
    localparam logic [2:0] IOB_IORESET = 3'd6;
    localparam logic [2:0] IOB_NOP     = 3'd7;

    typedef logic [2:0] iob_state_t;

    localparam iob_state_t ST_IDLE  = 3'd0;
    localparam iob_state_t ST_SETUP = 3'd1;
    localparam iob_state_t ST_CLR   = 3'd2;
    localparam iob_state_t ST_GAP   = 3'd3;
    localparam iob_state_t ST_SET   = 3'd4;
    localparam iob_state_t ST_READ  = 3'd5;
    localparam iob_state_t ST_RST   = 3'd6;
    localparam iob_state_t ST_DONE  = 3'd7;

    localparam logic [3:9] IOB_DEV_TTY = 7'b001_010_0;

    localparam int IOB_CNT_W = 16;

    // Each timed state runs for n cycles, so its counter starts at n-1.
    function automatic logic [IOB_CNT_W-1:0] iob_cnt_load(input int n);
        return IOB_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/iob_sync7.sv
// Two-flop synchroniser for the seven device PI request lines.
module iob_sync7 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:7] d,
    output logic [1:7] q
);

    logic [1:7] meta_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/iob_master_ka10.sv
// KA10 IO bus initiator: sequences one IOT at a time onto the bus levels and
// returns read data / skip results; also synchronises the PI request lines.
module iob_master_ka10
    import iob_ka10_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int CLR_CYC   = 4,
    parameter int GAP_CYC   = 2,
    parameter int SET_CYC   = 4,
    parameter int RD_CYC    = 4,
    parameter int RST_CYC   = 8,
    parameter int PWR_DLY   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:9]  cmd_dev,
    input  logic [0:35] cmd_data,
    output logic        rsp_valid,
    output logic [0:35] rsp_data,
    output logic        rsp_skip,
    output logic        iobus_iob_poweron,
    output logic        iobus_iob_reset,
    output logic        iobus_datao_clear,
    output logic        iobus_datao_set,
    output logic        iobus_cono_clear,
    output logic        iobus_cono_set,
    output logic        iobus_iob_fm_datai,
    output logic        iobus_iob_fm_status,
    output logic [3:9]  iobus_ios,
    output logic [0:35] iobus_iob_in,
    input  logic [0:35] iobus_iob_out,
    input  logic [1:7]  iobus_pi_req,
    output logic [1:7]  pi_req_sync
);

    if (SETUP_CYC < 1 || CLR_CYC < 1 || GAP_CYC < 1 || SET_CYC < 1 ||
        RD_CYC < 1 || RST_CYC < 1 || PWR_DLY < 1) begin : g_bad_cycle_count
        $error("iob_master_ka10: all cycle-count parameters must be >= 1");
    end

    iob_state_t           state;
    logic [IOB_CNT_W-1:0] cnt;
    logic [IOB_CNT_W-1:0] pwr_cnt;
    logic                 poweron_q;
    logic [2:0]           op_q;
    logic [3:9]           dev_q;
    logic [0:35]          data_q;
    logic                 hold_q;
    logic                 is_write;
    logic                 accept;

    assign is_write = (op_q == IOB_DATAO) || (op_q == IOB_CONO);
    assign accept   = cmd_valid && cmd_ready;

    function automatic logic skip_calc(input logic [2:0] op, input logic [0:35] sample,
                                       input logic [0:35] mask);
        logic any_set;
        any_set = |(sample[18:35] & mask[18:35]);
        case (op)
            IOB_CONSZ: return !any_set;
            IOB_CONSO: return any_set;
            default:   return 1'b0;
        endcase
    endfunction

    // Power-on delay restarts from zero every time reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwr_cnt   <= '0;
            poweron_q <= 1'b0;
        end else if (!poweron_q) begin
            if (pwr_cnt == iob_cnt_load(PWR_DLY)) poweron_q <= 1'b1;
            else                                  pwr_cnt   <= pwr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= IOB_NOP;
            dev_q    <= '0;
            data_q   <= '0;
            hold_q   <= 1'b0;
            rsp_data <= '0;
            rsp_skip <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    op_q     <= cmd_op;
                    dev_q    <= cmd_dev;
                    data_q   <= cmd_data;
                    hold_q   <= 1'b0;
                    rsp_data <= '0;
                    rsp_skip <= 1'b0;
                    case (cmd_op)
                        IOB_NOP:     state <= ST_DONE;
                        IOB_IORESET: begin state <= ST_RST;   cnt <= iob_cnt_load(RST_CYC);   end
                        default:     begin state <= ST_SETUP; cnt <= iob_cnt_load(SETUP_CYC); end
                    endcase
                end
                // SETUP is revisited for one hold cycle after SET so ios/iob_in
                // outlast the set strobe.
                ST_SETUP:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (hold_q) state <= ST_DONE;
                    else if (is_write) begin state <= ST_CLR;  cnt <= iob_cnt_load(CLR_CYC); end
                    else               begin state <= ST_READ; cnt <= iob_cnt_load(RD_CYC);  end
                ST_CLR:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin state <= ST_GAP; cnt <= iob_cnt_load(GAP_CYC); end
                ST_GAP:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin state <= ST_SET; cnt <= iob_cnt_load(SET_CYC); end
                ST_SET:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin state <= ST_SETUP; cnt <= '0; hold_q <= 1'b1; end
                ST_READ:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        state    <= ST_DONE;
                        rsp_data <= iobus_iob_out;
                        rsp_skip <= skip_calc(op_q, iobus_iob_out, data_q);
                    end
                ST_RST:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Levels decode straight from the state register so reset drops them at once.
    assign cmd_ready           = poweron_q && (state == ST_IDLE);
    assign rsp_valid           = (state == ST_DONE);
    assign iobus_iob_poweron   = poweron_q;
    assign iobus_iob_reset     = (state == ST_RST);
    assign iobus_datao_clear   = (state == ST_CLR)  && (op_q == IOB_DATAO);
    assign iobus_cono_clear    = (state == ST_CLR)  && (op_q == IOB_CONO);
    assign iobus_datao_set     = (state == ST_SET)  && (op_q == IOB_DATAO);
    assign iobus_cono_set      = (state == ST_SET)  && (op_q == IOB_CONO);
    assign iobus_iob_fm_datai  = (state == ST_READ) && (op_q == IOB_DATAI);
    assign iobus_iob_fm_status = (state == ST_READ) && (op_q != IOB_DATAI);

    always_comb begin
        iobus_ios    = '0;
        iobus_iob_in = '0;
        if (state == ST_SETUP || state == ST_CLR || state == ST_GAP ||
            state == ST_SET || state == ST_READ) begin
            iobus_ios = dev_q;
            if (is_write) iobus_iob_in = data_q;
        end
    end

    iob_sync7 u_pi_sync (
        .clk   (clk),
        .reset (reset),
        .d     (iobus_pi_req),
        .q     (pi_req_sync)
    );

endmodule

// File: tb/tb_iob_master_ka10.sv
// Directed-vector bench for iob_master_ka10 with a small status/data responder.
module tb_iob_master_ka10;
    import iob_ka10_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = IOB_NOP;
    logic [3:9]  cmd_dev = '0;
    logic [0:35] cmd_data = '0;
    logic        rsp_valid;
    logic [0:35] rsp_data;
    logic        rsp_skip;
    logic        iobus_iob_poweron, iobus_iob_reset;
    logic        iobus_datao_clear, iobus_datao_set, iobus_cono_clear, iobus_cono_set;
    logic        iobus_iob_fm_datai, iobus_iob_fm_status;
    logic [3:9]  iobus_ios;
    logic [0:35] iobus_iob_in;
    logic [0:35] iobus_iob_out;
    logic [1:7]  iobus_pi_req = '0;
    logic [1:7]  pi_req_sync;

    logic [0:35] status_word = 36'o000000000123;
    logic [0:35] datai_word  = 36'o000000000777;

    assign iobus_iob_out = (iobus_iob_fm_status ? status_word : 36'd0) |
                           (iobus_iob_fm_datai  ? datai_word  : 36'd0);

    always #5 clk = ~clk;

    iob_master_ka10 dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_dev             (cmd_dev),
        .cmd_data            (cmd_data),
        .rsp_valid           (rsp_valid),
        .rsp_data            (rsp_data),
        .rsp_skip            (rsp_skip),
        .iobus_iob_poweron   (iobus_iob_poweron),
        .iobus_iob_reset     (iobus_iob_reset),
        .iobus_datao_clear   (iobus_datao_clear),
        .iobus_datao_set     (iobus_datao_set),
        .iobus_cono_clear    (iobus_cono_clear),
        .iobus_cono_set      (iobus_cono_set),
        .iobus_iob_fm_datai  (iobus_iob_fm_datai),
        .iobus_iob_fm_status (iobus_iob_fm_status),
        .iobus_ios           (iobus_ios),
        .iobus_iob_in        (iobus_iob_in),
        .iobus_iob_out       (iobus_iob_out),
        .iobus_pi_req        (iobus_pi_req),
        .pi_req_sync         (pi_req_sync)
    );

    // Level trace bit order: {reset, datao_clear, datao_set, cono_clear, cono_set, fm_datai, fm_status}
    localparam int L_RST = 6, L_DC = 5, L_DS = 4, L_CC = 3, L_CS = 2, L_FD = 1, L_FS = 0;

    int          n_vec = 0;
    int          n_err = 0;
    logic [6:0]  lv_tr [0:63];
    logic [3:9]  ios_tr[0:63];
    logic [0:35] in_tr [0:63];
    int          n_trace = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] levels();
        return {iobus_iob_reset, iobus_datao_clear, iobus_datao_set, iobus_cono_clear,
                iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status};
    endfunction

    task automatic sample(input int c);
        lv_tr[c]  = levels();
        ios_tr[c] = iobus_ios;
        in_tr[c]  = iobus_iob_in;
    endtask

    task automatic clear_trace();
        for (int c = 0; c < 64; c++) begin
            lv_tr[c] = '0; ios_tr[c] = '0; in_tr[c] = '0;
        end
        n_trace = 0;
    endtask

    function automatic int cnt_lv(input int b);
        int n = 0;
        for (int c = 1; c <= n_trace; c++) if (lv_tr[c][b]) n++;
        return n;
    endfunction

    function automatic int first_lv(input int b);
        for (int c = 1; c <= n_trace; c++) if (lv_tr[c][b]) return c;
        return 0;
    endfunction

    function automatic int overlap_cnt();
        int n = 0;
        for (int c = 1; c <= n_trace; c++) if ($countones(lv_tr[c]) > 1) n++;
        return n;
    endfunction

    function automatic int adjacent_cnt();
        int n = 0;
        for (int c = 2; c <= n_trace; c++)
            if (lv_tr[c] != '0 && lv_tr[c-1] != '0 && lv_tr[c] != lv_tr[c-1]) n++;
        return n;
    endfunction

    // Called at a negedge with the master idle; returns with the master idle again.
    task automatic run_cmd(input logic [2:0] op, input logic [3:9] dev,
                           input logic [0:35] data, output int lat);
        int cyc;
        clear_trace();
        check_eq("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dev = dev; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        cyc = 1;
        while (lat == 0 && cyc < 48) begin
            sample(cyc);
            if (rsp_valid) lat = cyc;
            @(negedge clk);
            cyc++;
        end
        n_trace = cyc - 1;
    endtask

    int lat, lat1, lat2, acc2, pw_at, rdy_at, toggles, rv_cnt, cnt_a, cnt_b;
    logic [0:35] datai_rsp;

    initial begin
        // Power-on
        repeat (3) @(negedge clk);
        check_eq("rst_levels", 64'(levels()), 64'd0);
        check_eq("rst_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_rsp", 64'({rsp_valid, rsp_skip, rsp_data}), 64'd0);
        check_eq("rst_pi_sync", 64'(pi_req_sync), 64'd0);
        reset = 1'b1;
        pw_at = 0; rdy_at = 0; toggles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (iobus_iob_poweron && pw_at == 0) pw_at = k;
            if (cmd_ready && rdy_at == 0) rdy_at = k;
            if (pw_at == 0 && (levels() != '0 || iobus_ios != '0 || iobus_iob_in != '0)) toggles++;
        end
        check_eq("poweron_cycle", 64'(pw_at), 64'd16);
        check_eq("ready_cycle", 64'(rdy_at), 64'd16);
        check_eq("no_toggle_prepower", 64'(toggles), 64'd0);

        // DATAO to tty
        run_cmd(IOB_DATAO, IOB_DEV_TTY, 36'o101, lat);
        check_eq("datao_lat", 64'(lat), 64'd14);
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 13; c++) begin
            if (ios_tr[c] == IOB_DEV_TTY) cnt_a++;
            if (in_tr[c] == 36'o101) cnt_b++;
        end
        check_eq("datao_ios_cycles", 64'(cnt_a), 64'd13);
        check_eq("datao_in_cycles", 64'(cnt_b), 64'd13);
        check_eq("datao_done_bus_idle", 64'({ios_tr[14], in_tr[14]}), 64'd0);
        check_eq("datao_clr_first", 64'(first_lv(L_DC)), 64'd3);
        check_eq("datao_clr_len", 64'(cnt_lv(L_DC)), 64'd4);
        check_eq("datao_set_first", 64'(first_lv(L_DS)), 64'd9);
        check_eq("datao_set_len", 64'(cnt_lv(L_DS)), 64'd4);
        check_eq("datao_rsp", 64'({rsp_skip, rsp_data}), 64'd0);

        // CONI / CONSO / CONSZ against the status responder
        run_cmd(IOB_CONI, IOB_DEV_TTY, 36'd0, lat);
        check_eq("coni_lat", 64'(lat), 64'd7);
        check_eq("coni_fm_status_len", 64'(cnt_lv(L_FS)), 64'd4);
        check_eq("coni_data_held", 64'(rsp_data), 64'o123);
        check_eq("coni_skip", 64'(rsp_skip), 64'd0);
        cnt_a = 0;
        for (int c = 1; c <= n_trace; c++) if (in_tr[c] != '0) cnt_a++;
        check_eq("coni_iob_in_zero", 64'(cnt_a), 64'd0);
        run_cmd(IOB_CONSO, IOB_DEV_TTY, 36'o20, lat);
        check_eq("conso_20_skip", 64'(rsp_skip), 64'd1);
        check_eq("conso_20_data", 64'(rsp_data), 64'o123);
        run_cmd(IOB_CONSZ, IOB_DEV_TTY, 36'o4, lat);
        check_eq("consz_4_skip", 64'(rsp_skip), 64'd1);
        run_cmd(IOB_CONSZ, IOB_DEV_TTY, 36'o1, lat);
        check_eq("consz_1_skip", 64'(rsp_skip), 64'd0);
        check_eq("consz_lat", 64'(lat), 64'd7);

        // Back-to-back DATAI then CONO with cmd_valid held high
        clear_trace();
        cmd_valid = 1'b1; cmd_op = IOB_DATAI; cmd_dev = IOB_DEV_TTY; cmd_data = 36'd0;
        @(negedge clk);
        cmd_op = IOB_CONO; cmd_data = 36'o55;
        lat1 = 0; lat2 = 0; acc2 = 0; datai_rsp = '0;
        for (int c = 1; c <= 40 && lat2 == 0; c++) begin
            sample(c);
            n_trace = c;
            if (rsp_valid && lat1 == 0) begin lat1 = c; datai_rsp = rsp_data; end
            else if (rsp_valid) lat2 = c;
            if (acc2 != 0 && c == acc2 + 1) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready && acc2 == 0) acc2 = c;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("b2b_datai_lat", 64'(lat1), 64'd7);
        check_eq("b2b_datai_data", 64'(datai_rsp), 64'o777);
        check_eq("b2b_second_accept", 64'(acc2), 64'd8);
        check_eq("b2b_cono_lat", 64'(lat2), 64'd22);
        check_eq("b2b_fm_datai_len", 64'(cnt_lv(L_FD)), 64'd4);
        check_eq("b2b_cono_clr_len", 64'(cnt_lv(L_CC)), 64'd4);
        check_eq("b2b_cono_set_len", 64'(cnt_lv(L_CS)), 64'd4);
        check_eq("b2b_overlap", 64'(overlap_cnt()), 64'd0);
        check_eq("b2b_adjacent", 64'(adjacent_cnt()), 64'd0);

        // NOP
        run_cmd(IOB_NOP, IOB_DEV_TTY, 36'd0, lat);
        check_eq("nop_lat", 64'(lat), 64'd1);

        // Reset during the third CLR cycle of a CONO
        cmd_valid = 1'b1; cmd_op = IOB_CONO; cmd_dev = IOB_DEV_TTY; cmd_data = 36'o7;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("midrst_clr_before", 64'(iobus_cono_clear), 64'd1);
        #1 reset = 1'b0;
        #1;
        check_eq("midrst_clr_dropped", 64'(levels()), 64'd0);
        check_eq("midrst_poweron", 64'(iobus_iob_poweron), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pw_at = 0; rv_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) rv_cnt++;
            if (iobus_iob_poweron && pw_at == 0) pw_at = k;
        end
        check_eq("midrst_no_rsp", 64'(rv_cnt), 64'd0);
        check_eq("midrst_poweron_cycle", 64'(pw_at), 64'd16);

        // PI request synchroniser
        #3 iobus_pi_req = 7'b0010000;
        @(posedge clk); #1;
        check_eq("pi_sync_1clk", 64'(pi_req_sync), 64'd0);
        @(posedge clk); #1;
        check_eq("pi_sync_2clk", 64'(pi_req_sync), 64'(7'b0010000));
        @(negedge clk);

        // IORESET
        run_cmd(IOB_IORESET, IOB_DEV_TTY, 36'd0, lat);
        check_eq("ioreset_lat", 64'(lat), 64'd9);
        check_eq("ioreset_len", 64'(cnt_lv(L_RST)), 64'd8);
        check_eq("ioreset_first", 64'(first_lv(L_RST)), 64'd1);
        cnt_a = 0;
        for (int c = 1; c <= n_trace; c++) if (ios_tr[c] != '0) cnt_a++;
        check_eq("ioreset_ios_idle", 64'(cnt_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
